// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: sequencer FSM states, per-pipeline-register stall/flush control pair,
// and a helper sizing the MDU occupancy counter.
package pipeline_sequencer_pkg;

    typedef logic u1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MDU   = 2'd1,
        S_REDIR = 2'd2
    } seq_state_t;

    typedef struct packed {
        u1 stall;
        u1 flush;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_NONE  = '{stall: 1'b0, flush: 1'b0};
    localparam stage_ctl_t CTL_STALL = '{stall: 1'b1, flush: 1'b0};
    localparam stage_ctl_t CTL_FLUSH = '{stall: 1'b0, flush: 1'b1};

    // Counter only ever holds MDU_LATENCY-1 down to 1, never MDU_LATENCY itself.
    function automatic int cntWidth(input int latency);
        int w;
        w = $clog2(latency);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Bundle of hazard requests in and pipeline stall/flush/PC controls out.
// Latency: n/a (wiring only).
// Backpressure: n/a; requesters hold their request levels while stalled.
//
// Modports: master = pipeline side (drives requests, receives controls),
//           slave  = sequencer side.
interface pipeline_sequencer_if #(
    parameter int XLEN   = 64,
    parameter int PERF_W = 32
);
    logic              hazard_stall;
    logic              ireq_busy;
    logic              dreq_busy;
    logic              mdu_start;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    logic              stall_pc;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic              flush_w;
    logic              pc_load;
    logic [XLEN-1:0]   pc_target;
    logic              mdu_go;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output hazard_stall, ireq_busy, dreq_busy, mdu_start, redirect_valid, redirect_pc,
        input  stall_pc, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
        input  pc_load, pc_target, mdu_go, stall_cycles
    );

    modport slave (
        input  hazard_stall, ireq_busy, dreq_busy, mdu_start, redirect_valid, redirect_pc,
        output stall_pc, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
        output pc_load, pc_target, mdu_go, stall_cycles
    );
endinterface

// File: rtl/pipeline_sequencer_cycle_counter.sv
// Loadable down-counter that saturates at 1; tracks remaining MDU occupancy cycles.
// Latency: load/decrement visible the cycle after the edge; isOne is combinational.
// Backpressure: none; dec is ignored once the count reaches 1, load wins over dec.
//
// Ports: clk, resetn (sync, active-low), load/loadVal, dec, isOne.
module seq_cycle_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         dec,
    output logic         isOne
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && (cnt > W'(1))) begin
            cnt <= cnt - W'(1);
        end
    end

    assign isOne = (cnt == W'(1));
endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer for the 5-stage core: merges hazard, bus-wait, MDU and redirect.
// Latency: controls are combinational from state+requests; state/counters update on posedge clk.
// Backpressure: dbus wait freezes everything up to M; MDU and pending redirects wait behind it.
//
// Ports: clk, resetn (sync, active-low), bus (slave modport of pipeline_sequencer_if).
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int MDU_LATENCY = 8,
    parameter int XLEN        = 64,
    parameter int PERF_W      = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    pipeline_sequencer_if.slave  bus
);
    localparam int CW = cntWidth(MDU_LATENCY);

    seq_state_t        state, nextState;
    logic [XLEN-1:0]   pendPc;
    logic [PERF_W-1:0] stallCycles;
    stage_ctl_t        ctlD, ctlE, ctlM, ctlW;
    logic              stallPc, pcLoad, mduGo, pendLoad, cntIsOne;

    seq_cycle_counter #(.W(CW)) uCnt (
        .clk     (clk),
        .resetn  (resetn),
        .load    (mduGo),
        .loadVal (CW'(MDU_LATENCY - 1)),
        .dec     (state == S_MDU),
        .isOne   (cntIsOne)
    );

    always_comb begin
        stallPc   = 1'b0;
        ctlD      = CTL_NONE;
        ctlE      = CTL_NONE;
        ctlM      = CTL_NONE;
        ctlW      = CTL_NONE;
        pcLoad    = 1'b0;
        mduGo     = 1'b0;
        pendLoad  = 1'b0;
        nextState = state;
        if (!resetn) begin
            ctlD      = CTL_FLUSH;
            ctlE      = CTL_FLUSH;
            ctlM      = CTL_FLUSH;
            ctlW      = CTL_FLUSH;
            nextState = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (bus.dreq_busy) begin
                        stallPc = 1'b1;
                        ctlD    = CTL_STALL;
                        ctlE    = CTL_STALL;
                        ctlM    = CTL_STALL;
                        ctlW    = CTL_FLUSH;
                    end else if (bus.mdu_start) begin
                        stallPc   = 1'b1;
                        ctlD      = CTL_STALL;
                        ctlE      = CTL_STALL;
                        ctlM      = CTL_FLUSH;
                        mduGo     = 1'b1;
                        nextState = S_MDU;
                    end else if (bus.redirect_valid) begin
                        ctlD = CTL_FLUSH;
                        ctlE = CTL_FLUSH;
                        if (bus.ireq_busy) begin
                            // Cannot load the PC until the outstanding fetch returns.
                            stallPc   = 1'b1;
                            pendLoad  = 1'b1;
                            nextState = S_REDIR;
                        end else begin
                            pcLoad = 1'b1;
                        end
                    end else if (bus.hazard_stall) begin
                        stallPc = 1'b1;
                        ctlD    = CTL_STALL;
                        ctlE    = CTL_FLUSH;
                    end else if (bus.ireq_busy) begin
                        stallPc = 1'b1;
                        ctlD    = CTL_FLUSH;
                    end
                end
                S_MDU: begin
                    if (bus.dreq_busy) begin
                        stallPc = 1'b1;
                        ctlD    = CTL_STALL;
                        ctlE    = CTL_STALL;
                        ctlM    = CTL_STALL;
                        ctlW    = CTL_FLUSH;
                    end else if (!cntIsOne) begin
                        stallPc = 1'b1;
                        ctlD    = CTL_STALL;
                        ctlE    = CTL_STALL;
                        ctlM    = CTL_FLUSH;
                    end else begin
                        nextState = S_RUN;
                    end
                end
                S_REDIR: begin
                    // IF-ID always holds wrong-path work here, so flush wins over the
                    // dbus-wait hold for that register.
                    ctlD = CTL_FLUSH;
                    if (bus.dreq_busy) begin
                        stallPc = 1'b1;
                        ctlE    = CTL_STALL;
                        ctlM    = CTL_STALL;
                        ctlW    = CTL_FLUSH;
                    end else if (bus.ireq_busy) begin
                        stallPc = 1'b1;
                    end else begin
                        pcLoad    = 1'b1;
                        nextState = S_RUN;
                    end
                end
                default: nextState = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_RUN;
            pendPc      <= '0;
            stallCycles <= '0;
        end else begin
            state       <= nextState;
            if (pendLoad) begin
                pendPc <= bus.redirect_pc;
            end
            stallCycles <= stallCycles + PERF_W'(stallPc);
        end
    end

    assign bus.stall_pc     = stallPc;
    assign bus.stall_d      = ctlD.stall;
    assign bus.stall_e      = ctlE.stall;
    assign bus.stall_m      = ctlM.stall;
    assign bus.flush_d      = ctlD.flush;
    assign bus.flush_e      = ctlE.flush;
    assign bus.flush_m      = ctlM.flush;
    assign bus.flush_w      = ctlW.flush;
    assign bus.pc_load      = pcLoad;
    assign bus.pc_target    = (state == S_REDIR) ? pendPc : bus.redirect_pc;
    assign bus.mdu_go       = mduGo;
    assign bus.stall_cycles = stallCycles;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer (MDU_LATENCY=8, XLEN=64, PERF_W=4).
// Control vector order: {stall_pc,stall_d,stall_e,stall_m, flush_d,flush_e,flush_m,flush_w, pc_load,mdu_go}
// Stimulus vector order: {mdu_start, redirect_valid, hazard_stall, ireq_busy, dreq_busy}
module tb_pipeline_sequencer;
    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   goCount = 0;

    pipeline_sequencer_if #(.XLEN(64), .PERF_W(4)) bus ();

    pipeline_sequencer #(.MDU_LATENCY(8), .XLEN(64), .PERF_W(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [9:0] ctl;
    assign ctl = {bus.stall_pc, bus.stall_d, bus.stall_e, bus.stall_m,
                  bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w,
                  bus.pc_load, bus.mdu_go};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mdu_go === 1'b1) goCount++;

    task automatic drive(input logic [4:0] s);
        {bus.mdu_start, bus.redirect_valid, bus.hazard_stall, bus.ireq_busy, bus.dreq_busy} = s;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(5'b00000);
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.redirect_pc = 64'h0;
        drive(5'b11111);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (ctl !== 10'b0000111100) begin
                errors++; $display("FAIL reset_ctl cyc%0d got=%b exp=%b", i, ctl, 10'b0000111100);
            end
            checks++;
            if (bus.stall_cycles !== 4'd0) begin
                errors++; $display("FAIL reset_perf cyc%0d got=%0d exp=0", i, bus.stall_cycles);
            end
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        drive(5'b00000);
        #3;
        checks++;
        if (ctl !== 10'b0000000000) begin
            errors++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, 10'b0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mdu();
        logic [4:0] stim [9];
        logic [9:0] exp [9];
        int g0;
        stim = '{5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        exp  = '{10'b1110001001, 10'b1110001000, 10'b1110001000, 10'b1110001000, 10'b1110001000,
                 10'b1110001000, 10'b1110001000, 10'b0000000000, 10'b0000000000};
        do_reset();
        g0 = goCount;
        for (int i = 0; i < 9; i++) begin
            drive(stim[i]);
            #3;
            checks++;
            if (ctl !== exp[i]) begin
                errors++; $display("FAIL mdu cyc%0d got=%b exp=%b", i, ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.stall_cycles !== 4'd7) begin
            errors++; $display("FAIL mdu_perf got=%0d exp=7", bus.stall_cycles);
        end
        checks++;
        if (goCount - g0 !== 1) begin
            errors++; $display("FAIL mdu_go_count got=%0d exp=1", goCount - g0);
        end
    endtask

    task automatic test_mdu_dbus();
        logic [4:0] stim [13];
        logic [9:0] exp [13];
        int g0;
        do_reset();
        g0 = goCount;
        for (int i = 0; i < 13; i++) begin
            stim[i] = (i == 0) ? 5'b10000 : ((i <= 10) ? 5'b00001 : 5'b00000);
            exp[i]  = (i == 0) ? 10'b1110001001 : ((i <= 10) ? 10'b1111000100 : 10'b0000000000);
        end
        for (int i = 0; i < 13; i++) begin
            drive(stim[i]);
            #3;
            checks++;
            if (ctl !== exp[i]) begin
                errors++; $display("FAIL mdu_dbus cyc%0d got=%b exp=%b", i, ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.stall_cycles !== 4'd11) begin
            errors++; $display("FAIL mdu_dbus_perf got=%0d exp=11", bus.stall_cycles);
        end
        checks++;
        if (goCount - g0 !== 1) begin
            errors++; $display("FAIL mdu_dbus_go_count got=%0d exp=1", goCount - g0);
        end
    endtask

    task automatic test_redirect_idle();
        do_reset();
        bus.redirect_pc = 64'h0000_0000_8000_0040;
        drive(5'b01000);
        #3;
        checks++;
        if (ctl !== 10'b0000110010) begin
            errors++; $display("FAIL redir_idle_ctl got=%b exp=%b", ctl, 10'b0000110010);
        end
        checks++;
        if (bus.pc_target !== 64'h0000_0000_8000_0040) begin
            errors++; $display("FAIL redir_idle_target got=%h exp=%h", bus.pc_target, 64'h8000_0040);
        end
        @(posedge clk); #1;
        drive(5'b00000);
        #3;
        checks++;
        if (ctl !== 10'b0000000000) begin
            errors++; $display("FAIL redir_idle_after got=%b exp=%b", ctl, 10'b0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_redirect_busy();
        logic [4:0] stim [6];
        logic [9:0] exp [6];
        stim = '{5'b01010, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
        exp  = '{10'b1000110000, 10'b1000100000, 10'b1000100000, 10'b1000100000,
                 10'b0000100010, 10'b0000000000};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.redirect_pc = (i == 0) ? 64'h0000_0000_8000_0040 : 64'h0000_0000_DEAD_BEEF;
            drive(stim[i]);
            #3;
            checks++;
            if (ctl !== exp[i]) begin
                errors++; $display("FAIL redir_busy cyc%0d got=%b exp=%b", i, ctl, exp[i]);
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (bus.pc_target !== 64'h0000_0000_8000_0040) begin
                    errors++; $display("FAIL redir_busy_target cyc%0d got=%h exp=%h",
                                       i, bus.pc_target, 64'h8000_0040);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.stall_cycles !== 4'd4) begin
            errors++; $display("FAIL redir_busy_perf got=%0d exp=4", bus.stall_cycles);
        end
    endtask

    task automatic test_redirect_dbus();
        logic [4:0] stim [4];
        logic [9:0] exp [4];
        stim = '{5'b01010, 5'b00011, 5'b00000, 5'b00000};
        exp  = '{10'b1000110000, 10'b1011100100, 10'b0000100010, 10'b0000000000};
        do_reset();
        bus.redirect_pc = 64'h0000_0000_0000_1000;
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            #3;
            checks++;
            if (ctl !== exp[i]) begin
                errors++; $display("FAIL redir_dbus cyc%0d got=%b exp=%b", i, ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        logic [4:0] stim [6];
        logic [9:0] exp [6];
        int g0;
        stim = '{5'b01110, 5'b00100, 5'b00110, 5'b00010, 5'b10101, 5'b00000};
        exp  = '{10'b1000110000, 10'b0000100010, 10'b1100010000, 10'b1000100000,
                 10'b1111000100, 10'b0000000000};
        do_reset();
        g0 = goCount;
        bus.redirect_pc = 64'h0000_0000_0000_2000;
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            #3;
            checks++;
            if (ctl !== exp[i]) begin
                errors++; $display("FAIL priority cyc%0d got=%b exp=%b", i, ctl, exp[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.stall_cycles !== 4'd4) begin
            errors++; $display("FAIL priority_perf got=%0d exp=4", bus.stall_cycles);
        end
        checks++;
        if (goCount - g0 !== 0) begin
            errors++; $display("FAIL priority_go_count got=%0d exp=0", goCount - g0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(5'b10000);
        @(posedge clk); #1;
        drive(5'b00000);
        @(posedge clk); #1;
        resetn = 1'b0;
        #3;
        checks++;
        if (ctl !== 10'b0000111100) begin
            errors++; $display("FAIL reset_mid_ctl got=%b exp=%b", ctl, 10'b0000111100);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        #3;
        checks++;
        if (ctl !== 10'b0000000000) begin
            errors++; $display("FAIL reset_mid_after got=%b exp=%b", ctl, 10'b0);
        end
        checks++;
        if (bus.stall_cycles !== 4'd0) begin
            errors++; $display("FAIL reset_mid_perf got=%0d exp=0", bus.stall_cycles);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(5'b00100);
            #3;
            if (i == 15) begin
                checks++;
                if (bus.stall_cycles !== 4'd15) begin
                    errors++; $display("FAIL wrap_15 got=%0d exp=15", bus.stall_cycles);
                end
            end
            @(posedge clk); #1;
        end
        drive(5'b00000);
        #3;
        checks++;
        if (bus.stall_cycles !== 4'd0) begin
            errors++; $display("FAIL wrap_16 got=%0d exp=0", bus.stall_cycles);
        end
        @(posedge clk); #1;
        #3;
        checks++;
        if (bus.stall_cycles !== 4'd0) begin
            errors++; $display("FAIL wrap_idle got=%0d exp=0", bus.stall_cycles);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mdu();
        test_mdu_dbus();
        test_redirect_idle();
        test_redirect_busy();
        test_redirect_dbus();
        test_priority();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
